// File: rtl/one_to_four_demux.sv
// Purpose: buffered 1-to-4 stream demux; each word goes to the channel named by in_sel.
// Latency: one cycle from input acceptance to out_valid/out_dataK, with no bypass path.
// Backpressure: in_ready = !full[in_sel], so a stalled consumer blocks only words addressed to it.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_sel input stream;
//        out_valid[3:0]/out_ready[3:0]/out_data0..3 per-channel output streams;
//        out_count0..3 wrapping per-channel delivery counters; busy = any FIFO non-empty.

package soc_pkg;
    typedef logic [31:0] data_t;
endpackage

// Purpose: generic single-clock FIFO; the head is driven straight from storage and reads '0 when empty.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push_rdy drops when occupancy reaches DEPTH; a pop in the same cycle does not reopen it.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   OCC_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occ;
    logic          do_push;
    logic          do_pop;

    // Fullness comes from occupancy alone, so a simultaneous pop never lets a push through.
    assign push_rdy = (occ != OCC_FULL);
    assign pop_vld  = (occ != '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                occ <= occ + OCC_ONE;
            end else if (do_pop && !do_push) begin
                occ <= occ - OCC_ONE;
            end
        end
    end

    // Storage needs no reset: the head is masked to '0 whenever occupancy is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module one_to_four_demux
    import soc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  data_t            in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output data_t            out_data0,
    output data_t            out_data1,
    output data_t            out_data2,
    output data_t            out_data3,
    output logic [CNT_W-1:0] out_count0,
    output logic [CNT_W-1:0] out_count1,
    output logic [CNT_W-1:0] out_count2,
    output logic [CNT_W-1:0] out_count3,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0] push_vld;
    logic [3:0] push_rdy;
    data_t      head [4];

    // Depends only on in_sel and FIFO state, never on out_ready.
    assign in_ready = push_rdy[in_sel];

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;

        assign push_vld[k] = in_valid && (in_sel == 2'(k));

        sync_fifo #(
            .W     ($bits(data_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push_vld (push_vld[k]),
            .push_dat (in_data),
            .push_rdy (push_rdy[k]),
            .pop_vld  (out_valid[k]),
            .pop_rdy  (out_ready[k]),
            .pop_dat  (head[k])
        );

        // Delivery counter wraps silently at 2^CNT_W.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (out_valid[k] && out_ready[k]) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign out_data0  = head[0];
    assign out_data1  = head[1];
    assign out_data2  = head[2];
    assign out_data3  = head[3];
    assign out_count0 = g_ch[0].cnt_q;
    assign out_count1 = g_ch[1].cnt_q;
    assign out_count2 = g_ch[2].cnt_q;
    assign out_count3 = g_ch[3].cnt_q;

    // out_valid comes from the occupancy registers, so busy is glitch-free state.
    assign busy = |out_valid;
endmodule
